// File: rtl/jtag_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_mem_arbiter_if
// Description : Bus bundle between two requesters (A = JTAG debug loader,
//               B = secondary agent) and a shared single-port memory.
//               The arbiter connects through the slave modport. The
//               requesters and the memory connect through the master modport.
// Ports       : a_req/a_lock/a_we/a_addr/a_wdata  -> requests from port A
//               a_gnt/a_rvalid/a_rdata            <- accept/return to A
//               b_req/b_we/b_addr/b_wdata         -> requests from port B
//               b_gnt/b_rvalid/b_rdata            <- accept/return to B
//               mem_en/mem_we/mem_addr/mem_wdata  <- memory command
//               mem_rdata                         -> memory read data
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_mem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  // Port A (JTAG loader)
  logic              a_req;
  logic              a_lock;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  // Port B (second agent)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  a_req, a_lock, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output a_req, a_lock, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/jtag_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jtag_mem_arbiter
// Description : Round-robin arbiter that shares one single-port memory
//               between the JTAG loader (A) and a second agent (B). A can
//               hold a bounded lock across multi-word sequences. Each read
//               return is steered to the port that issued the read after a
//               fixed memory latency.
// Ports       : tck   - sole clock, rising edge
//               reset - asynchronous, active-high
//               bus   - jtag_mem_arbiter_if.slave (A, B and memory signals)
// Parameters  : DATA_W, ADDR_W, RD_LATENCY (1..4), MAX_LOCK (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_mem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  wire logic           tck,
  input  wire logic           reset,
  jtag_mem_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam logic [7:0] c_MAX_LOCK = MAX_LOCK[7:0];
  localparam logic [7:0] c_LCNT_SAT = 8'hFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  port_t                 r_last;
  logic                  r_locked;
  logic [7:0]            r_lcnt;
  // Read-tracking pipe: valid bit plus "issued by B" bit per stage.
  logic [RD_LATENCY-1:0] r_rd_vld;
  logic [RD_LATENCY-1:0] r_rd_isb;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [DATA_W-1:0]     r_a_rdata;
  logic [DATA_W-1:0]     r_b_rdata;

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  logic w_a_req;
  logic w_b_req;
  logic w_lock_hold;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_rd_push;
  logic w_ret_a;
  logic w_ret_b;

  always_comb begin
    // Requests are masked during reset so nothing reaches the memory.
    w_a_req     = bus.a_req & ~reset;
    w_b_req     = bus.b_req & ~reset;
    // A keeps ownership under contention only until the lock budget is spent;
    // once LCNT reaches MAX_LOCK the round-robin rule hands the slot to B.
    w_lock_hold = r_locked && (r_lcnt < c_MAX_LOCK);
    w_gnt_a     = w_a_req && (!w_b_req || w_lock_hold || (r_last == PORT_B));
    w_gnt_b     = w_b_req && !w_gnt_a;
    w_rd_push   = (w_gnt_a && !bus.a_we) || (w_gnt_b && !bus.b_we);
    w_ret_a     = r_rd_vld[RD_LATENCY-1] && !r_rd_isb[RD_LATENCY-1];
    w_ret_b     = r_rd_vld[RD_LATENCY-1] &&  r_rd_isb[RD_LATENCY-1];
  end

  // --------------------------------------------------------------------------
  // Memory command mux (all-zero when idle)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.mem_en    = w_gnt_a | w_gnt_b;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_gnt_a) begin
      bus.mem_we    = bus.a_we;
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
    end else if (w_gnt_b) begin
      bus.mem_we    = bus.b_we;
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
    end
  end

  assign bus.a_gnt    = w_gnt_a;
  assign bus.b_gnt    = w_gnt_b;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rdata  = r_b_rdata;

  // --------------------------------------------------------------------------
  // Ownership / lock bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      r_last   <= PORT_B;
      r_locked <= 1'b0;
      r_lcnt   <= 8'd0;
    end else if (w_gnt_a) begin
      r_last <= PORT_A;
      if (bus.a_lock) begin
        r_locked <= 1'b1;
        // Only grants made while the lock is already held count against the
        // budget, so A gets its opening grant plus MAX_LOCK locked grants.
        if (r_locked && w_b_req && (r_lcnt != c_LCNT_SAT)) begin
          r_lcnt <= r_lcnt + 8'd1;
        end
      end else begin
        r_locked <= 1'b0;
        r_lcnt   <= 8'd0;
      end
    end else if (w_gnt_b) begin
      r_last   <= PORT_B;
      r_locked <= 1'b0;
      r_lcnt   <= 8'd0;
    end else if (!bus.a_lock) begin
      // A lock that was held can only be seen with a_lock low on an idle
      // cycle if A has just released it, so this covers the falling edge.
      r_locked <= 1'b0;
      r_lcnt   <= 8'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Read tracking and return routing
  // --------------------------------------------------------------------------
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      r_rd_vld   <= '0;
      r_rd_isb   <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_push;
      r_rd_isb[0] <= w_gnt_b;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_isb[i] <= r_rd_isb[i-1];
      end
      // The last stage lines up with the cycle in which the memory drives
      // the data for that read.
      r_a_rvalid <= w_ret_a;
      r_b_rvalid <= w_ret_b;
      if (w_ret_a) begin
        r_a_rdata <= bus.mem_rdata;
      end
      if (w_ret_b) begin
        r_b_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire
